// File: rtl/shift_pkg.sv
// Shared encodings for the parametrised universal shift register.
package shift_pkg;

   // {S1,S0} mode encoding, same ordering as the 194-style shifter
   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SR   = 2'b01,
      MODE_SL   = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

   // Command sequencer states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-step combinational function: hold / shift right / shift left / load,
// with rotate and arithmetic-right variants.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  mode_t              mode,
   input  logic               ROT,
   input  logic               ARITH,
   input  logic               SL,
   input  logic               SR,
   input  logic [WIDTH-1:0]   PData,
   input  logic [WIDTH-1:0]   Q,
   output logic [WIDTH-1:0]   Q_next
);

   logic in_r;
   logic in_l;

   // Pick the fill bits, then apply the selected step
   always_comb begin
      in_r   = ROT ? Q[0] : (ARITH ? Q[WIDTH-1] : SR);
      in_l   = ROT ? Q[WIDTH-1] : SL;
      Q_next = Q;
      case (mode)
         MODE_HOLD: Q_next = Q;
         MODE_SR:   Q_next = {in_r, Q[WIDTH-1:1]};
         MODE_SL:   Q_next = {Q[WIDTH-2:0], in_l};
         MODE_LOAD: Q_next = PData;
         default:   Q_next = Q;
      endcase
   end

endmodule

// File: rtl/shift_reg_param_seq.sv
// Universal shift register with immediate mode plus a multi-cycle
// shift-by-N command reported through busy/done.
module shift_reg_param_seq
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               S1,
   input  logic               S0,
   input  logic               SL,
   input  logic               SR,
   input  logic               ROT,
   input  logic               ARITH,
   input  logic               start,
   input  logic [CNT_W-1:0]   amount,
   input  logic [WIDTH-1:0]   PData,
   output logic [WIDTH-1:0]   Q,
   output logic               busy,
   output logic               done
);

   state_t             state, state_n;
   mode_t              mode_l, mode_l_n;
   logic               rot_l, rot_l_n;
   logic               arith_l, arith_l_n;
   logic [CNT_W-1:0]   rem, rem_n;
   logic [WIDTH-1:0]   q_n, q_step;
   logic               busy_n, done_n;

   mode_t              mode_live;
   mode_t              st_mode;
   logic               st_rot, st_arith;
   logic [CNT_W-1:0]   amt_c;

   assign mode_live = mode_t'({S1, S0});
   assign amt_c     = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

   // Step controls: latched while running; an idle start only ever loads or holds
   always_comb begin
      st_mode  = mode_live;
      st_rot   = ROT;
      st_arith = ARITH;
      if (state == ST_RUN) begin
         st_mode  = mode_l;
         st_rot   = rot_l;
         st_arith = arith_l;
      end else if (start) begin
         st_mode = (mode_live == MODE_LOAD) ? MODE_LOAD : MODE_HOLD;
      end
   end

   shift_step #(.WIDTH(WIDTH)) u_step (
      .mode   (st_mode),
      .ROT    (st_rot),
      .ARITH  (st_arith),
      .SL     (SL),
      .SR     (SR),
      .PData  (PData),
      .Q      (Q),
      .Q_next (q_step)
   );

   // Next-state logic: accept commands in IDLE, count down steps in RUN
   always_comb begin
      state_n   = state;
      q_n       = q_step;
      busy_n    = busy;
      done_n    = 1'b0;
      rem_n     = rem;
      mode_l_n  = mode_l;
      rot_l_n   = rot_l;
      arith_l_n = arith_l;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if ((mode_live == MODE_SR || mode_live == MODE_SL) && amt_c != '0) begin
                  mode_l_n  = mode_live;
                  rot_l_n   = ROT;
                  arith_l_n = ARITH;
                  rem_n     = amt_c;
                  busy_n    = 1'b1;
                  state_n   = ST_RUN;
               end else begin
                  // load or empty command completes on the accept edge
                  done_n = 1'b1;
               end
            end
         end
         ST_RUN: begin
            rem_n = rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State and datapath registers; clear abandons any command in flight
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state   <= ST_IDLE;
         Q       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rem     <= '0;
         mode_l  <= MODE_HOLD;
         rot_l   <= 1'b0;
         arith_l <= 1'b0;
      end else begin
         state   <= state_n;
         Q       <= q_n;
         busy    <= busy_n;
         done    <= done_n;
         rem     <= rem_n;
         mode_l  <= mode_l_n;
         rot_l   <= rot_l_n;
         arith_l <= arith_l_n;
      end
   end

endmodule

// File: tb/tb_shift_reg_param_seq.sv
// Directed bench for shift_reg_param_seq at WIDTH=32 and WIDTH=8.
module tb_shift_reg_param_seq;

   logic        clk = 1'b0;
   logic        clear = 1'b0;
   logic        S1 = 1'b0, S0 = 1'b0, SL = 1'b0, SR = 1'b0;
   logic        ROT = 1'b0, ARITH = 1'b0, start = 1'b0;
   logic [5:0]  amount32 = '0;
   logic [3:0]  amount8 = '0;
   logic [31:0] pdata32 = '0;
   logic [7:0]  pdata8 = '0;
   logic [31:0] q32;
   logic [7:0]  q8;
   logic        busy32, done32, busy8, done8;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   shift_reg_param_seq #(.WIDTH(32)) u32 (
      .clk(clk), .clear(clear), .S1(S1), .S0(S0), .SL(SL), .SR(SR),
      .ROT(ROT), .ARITH(ARITH), .start(start), .amount(amount32),
      .PData(pdata32), .Q(q32), .busy(busy32), .done(done32)
   );

   shift_reg_param_seq #(.WIDTH(8)) u8 (
      .clk(clk), .clear(clear), .S1(S1), .S0(S0), .SL(SL), .SR(SR),
      .ROT(ROT), .ARITH(ARITH), .start(start), .amount(amount8),
      .PData(pdata8), .Q(q8), .busy(busy8), .done(done8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input logic [1:0] m);
      {S1, S0} = m;
   endtask

   task automatic do_clear();
      start = 1'b0;
      set_mode(2'b00);
      clear = 1'b1;
      #2;
      clear = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      pdata32 = 32'hDEAD_BEEF; pdata8 = 8'h5A;
      set_mode(2'b11);
      tick();
      do_clear();
      tests++;
      if (q32 !== 32'h0 || busy32 !== 1'b0 || done32 !== 1'b0 || q8 !== 8'h0) begin
         fails++;
         $display("FAIL reset: q32=%h busy=%b done=%b q8=%h, want 0/0/0/0", q32, busy32, done32, q8);
      end
   endtask

   task automatic test_arith_right();
      int bcnt;
      do_clear();
      pdata32 = 32'h8000_0001;
      set_mode(2'b11);
      tick();
      set_mode(2'b01); ROT = 1'b0; ARITH = 1'b1; SR = 1'b0;
      amount32 = 6'd4; start = 1'b1;
      tick();                                   // E0
      start = 1'b0; set_mode(2'b00); ARITH = 1'b0;
      tests++;
      if (busy32 !== 1'b1 || q32 !== 32'h8000_0001) begin
         fails++;
         $display("FAIL arith_accept: busy=%b q=%h, want 1 80000001", busy32, q32);
      end
      bcnt = 0;
      for (int i = 0; i < 10 && busy32; i++) begin
         bcnt++;
         tick();
      end
      tests++;
      if (bcnt !== 4 || done32 !== 1'b1 || q32 !== 32'hF800_0000) begin
         fails++;
         $display("FAIL arith_run: busycycles=%0d done=%b q=%h, want 4 1 f8000000", bcnt, done32, q32);
      end
      tick();
      tests++;
      if (done32 !== 1'b0 || busy32 !== 1'b0) begin
         fails++;
         $display("FAIL arith_done_pulse: done=%b busy=%b, want 0 0", done32, busy32);
      end
   endtask

   task automatic test_rotate_left();
      int edges;
      logic overlap;
      do_clear();
      pdata32 = 32'h1234_5678;
      set_mode(2'b11);
      tick();
      set_mode(2'b10); ROT = 1'b1; SL = 1'b0; amount32 = 6'd8; start = 1'b1;
      tick();
      start = 1'b0; set_mode(2'b00);
      for (int i = 0; i < 20 && !done32; i++) tick();
      tests++;
      if (done32 !== 1'b1 || q32 !== 32'h3456_7812) begin
         fails++;
         $display("FAIL rot8: done=%b q=%h, want 1 34567812", done32, q32);
      end
      // accept a full-width rotate on the done cycle
      set_mode(2'b10); amount32 = 6'd32; start = 1'b1;
      edges = 0; overlap = 1'b0;
      tick(); edges++;
      start = 1'b0; set_mode(2'b00); ROT = 1'b0;
      while (!done32 && edges < 60) begin
         if (done32 && busy32) overlap = 1'b1;
         tick(); edges++;
      end
      tests++;
      if (edges !== 33 || q32 !== 32'h3456_7812 || busy32 !== 1'b0 || overlap) begin
         fails++;
         $display("FAIL rot32: edges=%0d q=%h busy=%b, want 33 34567812 0", edges, q32, busy32);
      end
   endtask

   task automatic test_immediate();
      logic [3:0] pat;
      do_clear();
      pat = 4'b1101;                            // applied LSB first: 1,0,1,1
      set_mode(2'b10); ROT = 1'b0;
      for (int i = 0; i < 4; i++) begin
         SL = pat[i];
         tick();
      end
      tests++;
      if (q8 !== 8'h0B) begin
         fails++;
         $display("FAIL imm_left: q8=%h, want 0b", q8);
      end
      set_mode(2'b00); SL = 1'b1;
      tick(); tick(); tick();
      tests++;
      if (q8 !== 8'h0B) begin
         fails++;
         $display("FAIL imm_hold: q8=%h, want 0b", q8);
      end
      set_mode(2'b01); ROT = 1'b1;
      tick();
      set_mode(2'b00); ROT = 1'b0;
      tests++;
      if (q8 !== 8'h85) begin
         fails++;
         $display("FAIL imm_rotr: q8=%h, want 85", q8);
      end
   endtask

   task automatic test_back_to_back();
      set_mode(2'b01); amount8 = 4'd0; amount32 = 6'd0; start = 1'b1;
      tick();
      tests++;
      if (done8 !== 1'b1 || busy8 !== 1'b0 || q8 !== 8'h85) begin
         fails++;
         $display("FAIL zero_cmd: done=%b busy=%b q8=%h, want 1 0 85", done8, busy8, q8);
      end
      set_mode(2'b11); pdata8 = 8'hA5;
      tick();
      start = 1'b0; set_mode(2'b00);
      tests++;
      if (done8 !== 1'b1 || busy8 !== 1'b0 || q8 !== 8'hA5) begin
         fails++;
         $display("FAIL load_cmd: done=%b busy=%b q8=%h, want 1 0 a5", done8, busy8, q8);
      end
      tick();
      tests++;
      if (done8 !== 1'b0) begin
         fails++;
         $display("FAIL load_done_pulse: done=%b, want 0", done8);
      end
   endtask

   task automatic test_clear_midcmd();
      logic seen_done;
      do_clear();
      pdata32 = 32'h0F0F_0F0F;
      set_mode(2'b11);
      tick();
      set_mode(2'b01); amount32 = 6'd5; start = 1'b1;
      tick();                                   // E0, rem=5
      start = 1'b0; set_mode(2'b00);
      tick(); tick();                           // rem=3
      #3;
      clear = 1'b1;
      #1;
      tests++;
      if (q32 !== 32'h0 || busy32 !== 1'b0 || done32 !== 1'b0) begin
         fails++;
         $display("FAIL clear_mid: q=%h busy=%b done=%b, want 0 0 0", q32, busy32, done32);
      end
      clear = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done32 || busy32) seen_done = 1'b1;
      end
      tests++;
      if (seen_done) begin
         fails++;
         $display("FAIL clear_no_done: busy/done seen=%b, want 0", seen_done);
      end
   endtask

   task automatic test_start_while_busy();
      int bcnt;
      do_clear();
      pdata32 = 32'h0000_00FF;
      set_mode(2'b11);
      tick();
      set_mode(2'b10); ROT = 1'b0; SL = 1'b0; amount32 = 6'd3; start = 1'b1;
      tick();                                   // E0
      set_mode(2'b11); pdata32 = 32'h0; amount32 = 6'd10;
      bcnt = 0;
      for (int i = 0; i < 10 && busy32; i++) begin
         bcnt++;
         if (bcnt == 3) start = 1'b0;
         tick();
      end
      start = 1'b0; set_mode(2'b00);
      tests++;
      if (bcnt !== 3 || done32 !== 1'b1 || q32 !== 32'h0000_07F8) begin
         fails++;
         $display("FAIL busy_ignore: busycycles=%0d done=%b q=%h, want 3 1 000007f8", bcnt, done32, q32);
      end
      tick();
      tests++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || q32 !== 32'h0000_07F8) begin
         fails++;
         $display("FAIL busy_not_queued: busy=%b done=%b q=%h, want 0 0 000007f8", busy32, done32, q32);
      end
   endtask

   task automatic test_clamp();
      int bcnt;
      do_clear();
      set_mode(2'b01); ROT = 1'b0; ARITH = 1'b0; SR = 1'b1; amount32 = 6'd40; start = 1'b1;
      tick();
      start = 1'b0; set_mode(2'b00);
      bcnt = 0;
      for (int i = 0; i < 60 && busy32; i++) begin
         bcnt++;
         tick();
      end
      SR = 1'b0;
      tests++;
      if (bcnt !== 32 || done32 !== 1'b1 || q32 !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL clamp: busycycles=%0d done=%b q=%h, want 32 1 ffffffff", bcnt, done32, q32);
      end
   endtask

   initial begin
      test_reset();
      test_arith_right();
      test_rotate_left();
      test_immediate();
      test_back_to_back();
      test_clear_midcmd();
      test_start_while_busy();
      test_clamp();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_reg_param_seq.md
# shift_reg_param_seq

Parametrised universal shift register, successor of the fixed 32-bit four-mode shifter. It keeps the 194-style hold, shift-right, shift-left and parallel-load modes, with the same bit ordering, at any width. It adds rotate, arithmetic shift-right and a multi-cycle shift-by-N command with a busy/done handshake. It serves as the shift datapath for the ALU/serialiser labs, where a controller issues "shift by N" and waits for done.

## Interface
- WIDTH, 32: register width in bits, ≥ 2.
- CNT_W, $clog2(WIDTH+1): width of the shift-amount port.
- clk  in  1  clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- S1  in  1  mode select, high bit.
- S0  in  1  mode select, low bit. {S1,S0} encodes 00 hold, 01 shift right (toward bit 0), 10 shift left (toward MSB), 11 parallel load.
- SL  in  1  serial input entering Q[0] on a left shift.
- SR  in  1  serial input entering Q[WIDTH-1] on a right shift.
- ROT  in  1  when 1, shifts rotate: SL/SR are ignored and the bit shifted out re-enters at the other end.
- ARITH  in  1  when 1 (and ROT=0), a right shift inserts Q[WIDTH-1] instead of SR. ARITH has no effect on left shifts.
- start  in  1  request a multi-cycle command.
- amount  in  CNT_W  number of shifts for the command; values > WIDTH are clamped to WIDTH.
- PData  in  WIDTH  parallel load data.
- Q  out  WIDTH  register contents.
- busy  out  1  a multi-cycle command is in progress.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- One step function:
  - Hold: Q unchanged.
  - Shift right: Q ← {in_r, Q[WIDTH-1:1]}, where in_r = Q[0] if ROT=1, else Q[WIDTH-1] if ARITH=1, else SR.
  - Shift left: Q ← {Q[WIDTH-2:0], in_l}, where in_l = Q[WIDTH-1] if ROT=1, else SL.
  - Load: Q ← PData.
- State machine IDLE / RUN. Registered state: Q, busy, done, latched mode/ROT/ARITH, remaining count rem (CNT_W bits).
- IDLE, start=0: the step function uses the live S1,S0,ROT,ARITH, one step per cycle (immediate mode, identical to the 194 chain). done=0.
- IDLE, start=1, {S1,S0} ∈ {01,10}, clamped amount N ≥ 1:
  - Latch mode, ROT and ARITH.
  - Set rem=N and busy=1; Q unchanged on this edge; go to RUN.
- IDLE, start=1, {S1,S0}=11: load PData on this edge; done=1 for the next cycle; stay IDLE.
- IDLE, start=1, {S1,S0}=00 or N=0: Q unchanged; done=1 for the next cycle; stay IDLE.
- RUN: each edge performs one step with the latched mode/ROT/ARITH. SL and SR are sampled live each cycle for serial streaming. rem decrements.
  - On the edge where rem goes 1→0: busy←0, done←1, return to IDLE.
- While busy: S1, S0, ROT, ARITH, start and PData are ignored; start is dropped, not queued.
- done is high exactly one cycle per completed command and is never high while busy=1.
- Rotating by WIDTH leaves Q unchanged. A non-rotating shift by WIDTH leaves Q filled entirely with serial/sign bits.

## Timing
- Reset (clear=1, asynchronous): Q=0, busy=0, done=0, rem=0, state IDLE. A command in flight is abandoned, with no done pulse. The first edge after clear falls behaves as IDLE.
- Immediate mode: Q updates at the edge where the mode is sampled (latency 1).
- Shift command of N: accept edge E0, shifts at E1..EN, busy high from after E0 until after EN. done high for the cycle after EN. Total latency is N+1 edges from the accept edge to done.
- Load/zero command: done high for the cycle after E0; busy stays 0.
- A new start is accepted at the edge where done is high, so back-to-back commands have no dead cycle beyond the done cycle.

## Structure
- Package shift_pkg holds:
  - MODE_HOLD=2'b00, MODE_SR=2'b01, MODE_SL=2'b10, MODE_LOAD=2'b11.
  - State encoding ST_IDLE and ST_RUN.
- One combinational sub-module, shift_step, parametrised by WIDTH. Inputs: mode, ROT, ARITH, SL, SR, PData, Q. Output: Q_next.
- The top level holds the FSM, the counter and the registers, and instantiates shift_step once.

## Test plan
- WIDTH=32, load 0x8000_0001, ROT=0, ARITH=1, start right amount=4, SR=0 → busy for 4 cycles, Q=0xF800_0000, then a single done pulse.
- WIDTH=32, Q=0x1234_5678, ROT=1, start left amount=8 → Q=0x3456_7812 after 8 shifts; amount=32 → Q unchanged, done after 33 edges.
- WIDTH=8, immediate mode 10 with SL pattern 1,0,1,1 over 4 cycles from Q=0x00 → Q=0x0B; mode 00 for 3 cycles → Q stays 0x0B.
- Start with amount=0, then with mode 11 and PData=0xA5 (WIDTH=8) → each gives done one cycle later with busy=0; Q=0xA5 after the load.
- Clear asserted mid-command (rem=3) → Q=0, busy=0 immediately, with no done. Start while busy → ignored; the original command finishes on its count.
- amount=40 with WIDTH=32, non-rotating right shift, SR=1 → clamped to 32; Q=0xFFFF_FFFF, busy for exactly 32 cycles.
